// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: default key size, controller state encoding and
// small helpers used by the stream controller and the RC4 core.
package rc4_pkg;

  localparam int RC4_KEY_SIZE  = 16;
  localparam int KS_FIFO_DEPTH = 8;
  localparam int KS_WIDTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RUN   = 3'd4
  } rc4_ctrl_state_e;

  // True in the states where core output bytes are accepted into the buffer.
  function automatic logic is_streaming(rc4_ctrl_state_e s);
    return (s == ST_WAIT) || (s == ST_RUN);
  endfunction

  // True in the states where the RC4 core is held in reset.
  function automatic logic holds_core_reset(rc4_ctrl_state_e s);
    return (s == ST_IDLE) || (s == ST_RESET);
  endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream byte buffer. Head byte is presented combinationally, so a byte
// is visible the cycle after it is written. A push into a full buffer is
// accepted only if a pop frees a slot in the same cycle; otherwise the byte
// is dropped and reported on the dropped strobe.
module rc4_ks_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_FILL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fill;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign valid   = (fill != '0);
  assign full    = (fill == FULL_FILL);
  assign do_pop  = pop && valid && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dropped = push && !flush && full && !do_pop;
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointers wrap naturally at DEPTH; fill tracks occupancy 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rc4_stream_ctrl.sv
// RC4 stream controller: holds the host key, resets the external RC4 core,
// feeds it the key one byte per cycle, then buffers its keystream output.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | core held in reset, host may write key bytes
//   RESET  | one-cycle core reset after an accepted start
//   LOAD   | core_key walks key_buf[0..KEY_SIZE-1], one byte per cycle
//   WAIT   | key loaded, waiting for the core's first valid byte
//   RUN    | every core_ready byte is pushed into the keystream buffer
module rc4_stream_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_SIZE   = RC4_KEY_SIZE,
  parameter int FIFO_DEPTH = KS_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_we,
  input  logic [$clog2(KEY_SIZE)-1:0] key_addr,
  input  logic [7:0]                  key_wdata,
  input  logic                        start,
  input  logic                        stop,
  output logic [7:0]                  ks_data,
  output logic                        ks_valid,
  input  logic                        ks_ready,
  output logic                        busy,
  output logic                        overflow,
  output logic                        core_rst,
  output logic [7:0]                  core_key,
  input  logic                        core_ready,
  input  logic [7:0]                  core_k
);

  localparam int IW = $clog2(KEY_SIZE);
  localparam logic [IW-1:0] LOAD_LAST = IW'(KEY_SIZE - 1);

  rc4_ctrl_state_e state;
  rc4_ctrl_state_e state_nxt;
  logic [IW-1:0]   load_left;
  logic [IW-1:0]   load_left_nxt;
  logic [IW-1:0]   load_idx;
  logic [7:0]      key_buf [KEY_SIZE];

  logic start_ok;
  logic abort;
  logic push;
  logic pop;
  logic dropped;

  assign abort    = stop && (state != ST_IDLE);
  assign start_ok = (state == ST_IDLE) && start && !stop;
  assign load_idx = LOAD_LAST - load_left;
  assign push     = is_streaming(state) && core_ready && !stop;
  assign pop      = ks_valid && ks_ready;
  assign busy     = (state != ST_IDLE);

  // Host key buffer; writable only while idle so a running load is stable.
  always_ff @(posedge clk) begin
    if (key_we && (state == ST_IDLE)) key_buf[key_addr] <= key_wdata;
  end

  // State register and LOAD down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      load_left <= '0;
    end else begin
      state     <= state_nxt;
      load_left <= load_left_nxt;
    end
  end

  // Next-state decode; stop overrides everything outside IDLE.
  always_comb begin
    state_nxt     = state;
    load_left_nxt = load_left;
    core_key      = 8'h00;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_RESET;
      end
      ST_RESET: begin
        state_nxt     = ST_LOAD;
        load_left_nxt = LOAD_LAST;
      end
      ST_LOAD: begin
        core_key = key_buf[load_idx];
        if (load_left == '0) state_nxt = ST_WAIT;
        else                 load_left_nxt = load_left - 1'b1;
      end
      ST_WAIT: begin
        if (core_ready) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Core reset is registered from the next state so it lines up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) core_rst <= 1'b1;
    else     core_rst <= holds_core_reset(state_nxt);
  end

  // Sticky drop flag, cleared only by an accepted start or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overflow <= 1'b0;
    else if (start_ok) overflow <= 1'b0;
    else if (dropped)  overflow <= 1'b1;
  end

  rc4_ks_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KS_WIDTH)
  ) u_ks_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data (core_k),
    .pop       (pop),
    .head      (ks_data),
    .valid     (ks_valid),
    .dropped   (dropped)
  );

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Bench for rc4_stream_ctrl: a behavioural RC4 core drives the core side,
// and a queue-based reference model predicts every controller output.
module tb_rc4_stream_ctrl;

  localparam int KS    = 16;
  localparam int DEPTH = 8;
  localparam int NKS   = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_we;
  logic [3:0] key_addr;
  logic [7:0] key_wdata;
  logic       start;
  logic       stop;
  logic [7:0] ks_data;
  logic       ks_valid;
  logic       ks_ready;
  logic       busy;
  logic       overflow;
  logic       core_rst;
  logic [7:0] core_key;
  logic       core_ready;
  logic [7:0] core_k;

  rc4_stream_ctrl #(.KEY_SIZE(KS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_we     (key_we),
    .key_addr   (key_addr),
    .key_wdata  (key_wdata),
    .start      (start),
    .stop       (stop),
    .ks_data    (ks_data),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .busy       (busy),
    .overflow   (overflow),
    .core_rst   (core_rst),
    .core_key   (core_key),
    .core_ready (core_ready),
    .core_k     (core_k)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [7:0] key_model [KS];
  logic [7:0] exp_ks    [NKS];
  logic [7:0] q [$];
  bit         m_active;
  bit         m_ovf;
  int         m_cyc;
  int         push_cnt;

  // behavioural core
  logic [7:0] cap_key [KS];
  logic [7:0] core_ks [NKS];
  int         core_cnt;
  int         core_wait;
  int         core_pos;
  int         core_pct;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Plain RC4 (KSA + PRGA) over either the model key or the key the core saw.
  task automatic rc4_make(input bit for_core);
    logic [7:0] s [256];
    logic [7:0] i, j, t, kb;
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 8'h00;
    for (int n = 0; n < 256; n++) begin
      kb = for_core ? cap_key[n % KS] : key_model[n % KS];
      j = j + s[n] + kb;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 8'h00;
    j = 8'h00;
    for (int n = 0; n < NKS; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      if (for_core) core_ks[n] = s[t];
      else          exp_ks[n]  = s[t];
    end
  endtask

  // Core: captures KEY_SIZE key bytes after its reset drops, waits a little,
  // then emits keystream with random gaps.
  task automatic core_step();
    if (core_rst) begin
      core_cnt   = 0;
      core_ready = 1'b0;
      core_k     = 8'($urandom);
    end else if (core_cnt < KS) begin
      cap_key[core_cnt] = core_key;
      core_cnt++;
      core_ready = 1'b0;
      core_k     = 8'($urandom);
      if (core_cnt == KS) begin
        rc4_make(1'b1);
        core_pos  = 0;
        core_wait = $urandom_range(0, 2);
      end
    end else if (core_wait > 0) begin
      core_wait--;
      core_ready = 1'b0;
      core_k     = 8'($urandom);
    end else begin
      core_ready = ($urandom_range(0, 99) < core_pct) && (core_pos < NKS);
      core_k     = core_ready ? core_ks[core_pos] : 8'($urandom);
      if (core_ready) core_pos++;
    end
  endtask

  // One cycle: check outputs at the falling edge, drive the core, advance
  // the model for the coming rising edge.
  task automatic step();
    logic [7:0] exp_key;
    bit do_pop, do_push;
    check_val("ks_valid", ks_valid, (q.size() != 0));
    check_val("ks_data", ks_data, (q.size() != 0) ? q[0] : 8'h00);
    check_val("overflow", overflow, m_ovf);
    check_val("busy", busy, m_active);
    check_val("core_rst", core_rst, !(m_active && m_cyc >= 1));
    exp_key = (m_active && m_cyc >= 1 && m_cyc <= KS) ? key_model[m_cyc-1] : 8'h00;
    check_val("core_key", core_key, exp_key);
    core_step();
    do_pop  = (q.size() != 0) && ks_ready;
    do_push = m_active && core_ready && (m_cyc >= KS + 1);
    if (m_active && stop) begin
      m_active = 0;
      q.delete();
    end else if (!m_active) begin
      if (key_we) key_model[key_addr] = key_wdata;
      if (start && !stop) begin
        m_active = 1;
        m_cyc    = 0;
        m_ovf    = 0;
        push_cnt = 0;
        rc4_make(1'b0);
      end
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (q.size() < DEPTH) q.push_back(exp_ks[push_cnt]);
        else                  m_ovf = 1;
        if (push_cnt < NKS - 1) push_cnt++;
      end
      m_cyc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_key(input int a, input logic [7:0] d);
    key_we    = 1'b1;
    key_addr  = a[3:0];
    key_wdata = d;
    step();
    key_we    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_valid"}, ks_valid, 1'b0);
    check_val({tag, "_core_rst"}, core_rst, 1'b1);
  endtask

  initial begin
    int n;
    int p_ready;
    int len;
    rst = 1'b1; start = 1'b0; stop = 1'b0; key_we = 1'b0; key_addr = '0;
    key_wdata = '0; ks_ready = 1'b0; core_ready = 1'b0; core_k = '0;
    m_active = 0; m_ovf = 0; m_cyc = 0; push_cnt = 0;
    core_cnt = 0; core_wait = 0; core_pos = 0; core_pct = 100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ks_valid", ks_valid, 1'b0);
    check_val("rst_ks_data", ks_data, 8'h00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_core_rst", core_rst, 1'b1);
    check_val("rst_core_key", core_key, 8'h00);
    check_val("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    step();

    // Key 00..0F, consumer always ready.
    for (int i = 0; i < KS; i++) write_key(i, i[7:0]);
    ks_ready = 1'b1;
    do_start();
    repeat (60) step();
    do_stop("run1_stop");

    // Consumer stalled: fill to depth, drop, then drain in order.
    // A key write during LOAD must be ignored.
    ks_ready = 1'b0;
    do_start();
    repeat (5) step();
    write_key(3, 8'hFF);
    n = 0;
    while (!m_ovf && n < 100) begin step(); n++; end
    check_val("ovf_wait_bound", (n < 100), 1'b1);
    check_val("ovf_set", overflow, 1'b1);
    ks_ready = 1'b1;
    repeat (30) step();
    check_val("ovf_sticky", overflow, 1'b1);
    do_stop("run2_stop");

    // stop while waiting for the core's first byte
    do_start();
    n = 0;
    while (m_cyc != KS + 1 && n < 100) begin step(); n++; end
    check_val("wait_bound", (n < 100), 1'b1);
    do_stop("stop_wait");

    // stop during RUN with 5 bytes buffered
    ks_ready = 1'b0;
    do_start();
    n = 0;
    while (q.size() != 5 && n < 100) begin step(); n++; end
    check_val("fill5_bound", (n < 100), 1'b1);
    check_val("fill5_valid", ks_valid, 1'b1);
    do_stop("stop_run");

    // Full buffer, consumer ready every cycle: simultaneous push/pop never drops.
    do_start();
    n = 0;
    while (q.size() != DEPTH && n < 100) begin step(); n++; end
    check_val("full_bound", (n < 100), 1'b1);
    ks_ready = 1'b1;
    repeat (40) step();
    check_val("full_no_ovf", overflow, 1'b0);
    do_stop("run5_stop");

    // start+stop together in IDLE: start is not taken
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_val("start_stop_idle", busy, 1'b0);

    // Reset mid-RUN after an overflow, then restart with the same key.
    ks_ready = 1'b0;
    do_start();
    n = 0;
    while (!m_ovf && n < 100) begin step(); n++; end
    check_val("ovf2_set", overflow, 1'b1);
    rst = 1'b1;
    #1;
    check_val("arst_ks_valid", ks_valid, 1'b0);
    check_val("arst_ks_data", ks_data, 8'h00);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_core_rst", core_rst, 1'b1);
    check_val("arst_core_key", core_key, 8'h00);
    check_val("arst_overflow", overflow, 1'b0);
    m_active = 0; m_ovf = 0; q.delete();
    core_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    ks_ready = 1'b1;
    do_start();
    repeat (50) step();
    do_stop("rerun_stop");

    // Random keys, random consumer and core pacing, stray starts and writes.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < KS; i++) write_key(i, 8'($urandom));
      core_pct = $urandom_range(30, 100);
      p_ready  = $urandom_range(10, 100);
      len      = $urandom_range(30, 150);
      do_start();
      for (int c = 0; c < len; c++) begin
        ks_ready  = ($urandom_range(0, 99) < p_ready);
        start     = ($urandom_range(0, 19) == 0);
        key_we    = ($urandom_range(0, 19) == 0);
        key_addr  = 4'($urandom);
        key_wdata = 8'($urandom);
        step();
      end
      start = 1'b0; key_we = 1'b0;
      do_stop("rand_stop");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
